// File: rtl/key_debounce_if.sv
// Push-button front-end bundle: raw button level in, debounced level and event pulses out.
// The debouncer uses the slave modport; whoever drives the button and consumes events uses master.
interface key_debounce_if;
  logic button_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;
  logic key_repeat;

  modport master (
    output button_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

  modport slave (
    input  button_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat
  );
endinterface

// File: rtl/key_debounce.sv
// Debounces a raw push-button into a clean level plus press/release/long/repeat pulses.
// All outputs come straight from flops; press/release trail the raw edge by DEBOUNCE_CYCLES+2.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 100,
  parameter int REPEAT_CYCLES   = 30,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic          clk,
  input  logic          rst,
  key_debounce_if.slave kb
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    LONG,
    DB_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             long_seen_q, long_seen_d;
  logic             key_level_q, key_level_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;
  logic             key_long_q, key_long_d;
  logic             key_repeat_q, key_repeat_d;

  // The raw button is asynchronous; only s2 is ever looked at by the FSM.
  always_comb begin
    s1_d = kb.button_in;
    s2_d = s1_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_cnt_d    = hold_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    long_seen_d   = long_seen_q;
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    key_long_d    = 1'b0;
    key_repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          key_press_d = 1'b1;
          key_level_d = 1'b1;
          hold_cnt_d  = '0;
          long_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d     = LONG;
          key_long_d  = 1'b1;
          long_seen_d = 1'b1;
          rep_cnt_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      LONG: begin
        if (!s2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          key_repeat_d = REPEAT_EN;
          rep_cnt_d    = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
      end

      DB_RELEASE: begin
        // A release bounce resumes the hold where it left off, so no counter is touched.
        if (s2_q) begin
          state_d = long_seen_q ? LONG : PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d       = IDLE;
          key_release_d = 1'b1;
          key_level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      cnt_q         <= '0;
      hold_cnt_q    <= '0;
      rep_cnt_q     <= '0;
      long_seen_q   <= 1'b0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      key_repeat_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      cnt_q         <= cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      long_seen_q   <= long_seen_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_repeat_q  <= key_repeat_d;
    end
  end

  assign kb.key_level   = key_level_q;
  assign kb.key_press   = key_press_q;
  assign kb.key_release = key_release_q;
  assign kb.key_long    = key_long_q;
  assign kb.key_repeat  = key_repeat_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: one DUT with repeat enabled, one with it disabled, same button.
module tb_key_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;

  int press_n = 0, release_n = 0, long_n = 0, rep_n = 0, clash_n = 0;
  int long1_n = 0, rep1_n = 0;
  int press_at = -1, release_at = -1, long_at = -1;
  int rep_at[$];

  int n, r, m;
  int b_press, b_release, b_long, b_rep, b_long1, b_rep1;

  key_debounce_if bus0 ();
  key_debounce_if bus1 ();

  assign bus0.button_in = btn;
  assign bus1.button_in = btn;

  key_debounce #(.DEBOUNCE_CYCLES(20), .LONG_CYCLES(100), .REPEAT_CYCLES(30), .REPEAT_EN(1'b1), .CNT_W(32))
    u_dut (.clk(clk), .rst(rst), .kb(bus0));

  key_debounce #(.DEBOUNCE_CYCLES(20), .LONG_CYCLES(100), .REPEAT_CYCLES(30), .REPEAT_EN(1'b0), .CNT_W(32))
    u_dut_norep (.clk(clk), .rst(rst), .kb(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Pulse recorder: edge_no here is the posedge that launched the pulse being observed.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.key_press)   begin press_n++;   press_at = edge_no;   end
      if (bus0.key_release) begin release_n++; release_at = edge_no; end
      if (bus0.key_long)    begin long_n++;    long_at = edge_no;    end
      if (bus0.key_repeat)  begin rep_n++;     rep_at.push_back(edge_no); end
      if ((bus0.key_long || bus0.key_repeat) && (bus0.key_press || bus0.key_release)) clash_n++;
      if (bus1.key_long)    long1_n++;
      if (bus1.key_repeat)  rep1_n++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic snap();
    b_press = press_n; b_release = release_n; b_long = long_n; b_rep = rep_n;
    b_long1 = long1_n; b_rep1 = rep1_n;
  endtask

  initial begin
    // Reset state
    cyc(3);
    check("rst_level",   int'(bus0.key_level),   0);
    check("rst_press",   int'(bus0.key_press),   0);
    check("rst_release", int'(bus0.key_release), 0);
    check("rst_long",    int'(bus0.key_long),    0);
    check("rst_repeat",  int'(bus0.key_repeat),  0);
    rst = 1'b0;
    cyc(5);

    // 1: clean press held 40 cycles, clean release
    snap();
    btn = 1'b1; n = edge_no + 1;
    cyc(40);
    check("t1_press_cnt",  press_n - b_press, 1);
    check("t1_press_at",   press_at - n, 22);
    check("t1_level_hi",   int'(bus0.key_level), 1);
    btn = 1'b0; r = edge_no + 1;
    cyc(30);
    check("t1_release_cnt", release_n - b_release, 1);
    check("t1_release_at",  release_at - r, 22);
    check("t1_level_lo",    int'(bus0.key_level), 0);
    check("t1_no_long",     long_n - b_long, 0);

    // 2: three short high glitches
    snap();
    for (int g = 0; g < 3; g++) begin
      btn = 1'b1; cyc(5);
      btn = 1'b0; cyc(5);
    end
    cyc(30);
    check("t2_no_press",   press_n - b_press, 0);
    check("t2_no_release", release_n - b_release, 0);
    check("t2_level",      int'(bus0.key_level), 0);

    // 3 + 6: hold 250 cycles; repeats at +152/+182/+212/+242
    snap();
    btn = 1'b1; n = edge_no + 1;
    cyc(250);
    check("t3_press_at", press_at - n, 22);
    check("t3_long_cnt", long_n - b_long, 1);
    check("t3_long_at",  long_at - n, 122);
    check("t3_rep_cnt",  rep_n - b_rep, 4);
    if (rep_n - b_rep >= 3) begin
      check("t3_rep0_at", rep_at[b_rep]     - n, 152);
      check("t3_rep1_at", rep_at[b_rep + 1] - n, 182);
      check("t3_rep2_at", rep_at[b_rep + 2] - n, 212);
    end
    check("t6_long_cnt", long1_n - b_long1, 1);
    check("t6_rep_cnt",  rep1_n - b_rep1, 0);
    btn = 1'b0;
    cyc(30);
    check("t3_release_cnt", release_n - b_release, 1);

    // 4: 5-cycle low glitch at N+60; held time stalls for 6 FSM edges
    snap();
    btn = 1'b1; n = edge_no + 1;
    cyc(60);
    btn = 1'b0;
    cyc(5);
    btn = 1'b1;
    cyc(140);
    check("t4_press_cnt",   press_n - b_press, 1);
    check("t4_no_release",  release_n - b_release, 0);
    check("t4_long_cnt",    long_n - b_long, 1);
    check("t4_long_at",     long_at - n, 128);
    check("t4_level",       int'(bus0.key_level), 1);
    btn = 1'b0;
    cyc(30);
    check("t4_release_cnt", release_n - b_release, 1);

    // 5: reset while key_repeat is high in LONG, then re-press from scratch
    btn = 1'b1; n = edge_no + 1;
    cyc(153);
    check("t5_rep_live",  int'(bus0.key_repeat), 1);
    check("t5_level_pre", int'(bus0.key_level), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_level",  int'(bus0.key_level),  0);
    check("t5_rst_repeat", int'(bus0.key_repeat), 0);
    check("t5_rst_press",  int'(bus0.key_press),  0);
    check("t5_rst_long",   int'(bus0.key_long),   0);
    cyc(2);
    snap();
    rst = 1'b0; m = edge_no + 1;
    cyc(40);
    check("t5_repress_cnt", press_n - b_press, 1);
    check("t5_repress_at",  press_at - m, 22);
    btn = 1'b0;
    cyc(30);

    check("no_clash",       clash_n, 0);
    check("norep_never",    rep1_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
